hit_scheduler: RTL and testbench
================================

Name: hit_scheduler

Overview:
- Per-frame collision scheduler: time-multiplexes one rectangle-overlap comparator across NUM_ENEMIES enemy ships and NUM_LASERS user lasers.
- Started by a frame pulse; walks every (enemy, laser) pair, resolves each laser to at most one enemy, reports hit vectors over a valid/ack handshake.
- Sits between the enemy/laser movement logic and the game-state/score logic; replaces per-pair comparators instanced per ship.

Parameters:
- NUM_ENEMIES, 4, number of enemy slots (1..16)
- NUM_LASERS, 2, number of user laser slots (1..8)
- ENEMY_SIZE, 30, enemy square side in pixels
- LASER_W, 20, laser width in pixels
- LASER_H, 49, laser height in pixels

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; requests a scan
- enemy_alive  in  NUM_ENEMIES  bit i = enemy i present
- enemy_x_flat, enemy_y_flat  in  10*NUM_ENEMIES each  enemy i top-left at bits [10i+9:10i]
- laser_active  in  NUM_LASERS  bit j = laser j in flight
- laser_x_flat, laser_y_flat  in  10*NUM_LASERS each  laser j top-left, same packing
- busy  out  1  high from scan start until ack accepted
- hits_valid  out  1  result vectors valid
- hits_ack  in  1  consumer accepts result
- enemy_hit_vec  out  NUM_ENEMIES  enemies hit this frame
- laser_hit_vec  out  NUM_LASERS  lasers consumed this frame
- overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset: state IDLE; busy, hits_valid, overrun = 0; enemy_hit_vec, laser_hit_vec = 0; indices e = l = 0.
- States: IDLE, SCAN, REPORT.
- IDLE: frame_start=1 -> clear both vectors, e=0, l=0, busy=1 next cycle, go SCAN.
- SCAN: one pair per cycle, laser-major order: l outer, e inner (l=0: e=0..N-1, then l=1 ...). Exactly NUM_ENEMIES*NUM_LASERS cycles regardless of alive/active.
- Pair (e,l) hits iff enemy_alive[e] & laser_active[l] & !laser_hit_vec[l] & !enemy_hit_vec[e] & overlap.
- Overlap (inclusive, 11-bit unsigned, no wrap): lx <= ex+ENEMY_SIZE, lx+LASER_W >= ex, ly <= ey+ENEMY_SIZE, ly+LASER_H >= ey.
- Hit sets enemy_hit_vec[e] and laser_hit_vec[l] at the clock edge ending that pair's cycle. The lowest-index enemy wins a laser. An enemy takes at most one laser; the lower-index laser wins.
- After the last pair (e=N-1, l=M-1): go REPORT; hits_valid=1 on the following cycle.
- REPORT: hits_valid and vectors held stable until hits_ack=1 is sampled. At that edge, hits_valid=0, busy=0, go IDLE. hits_ack outside REPORT is ignored.
- Scan-to-valid latency from frame_start: N*M+1 cycles (valid visible on cycle N*M+2).
- Position and alive/active inputs are required stable while busy. No snapshot is taken.
- frame_start while busy: ignored, scan not restarted, overrun set to 1. overrun is cleared only by Reset.
- frame_start and hits_ack in the same REPORT cycle: ack is taken, IDLE entered, overrun set, frame dropped.
- Reset mid-SCAN or mid-REPORT: immediate return to reset values next edge; partial results discarded.

Optional Feature:
- Macro HIT_SCORE_EN.
- Defined: adds output score (16 bits, reset 0). On the ack edge, adds popcount(enemy_hit_vec)*10, saturating at 16'hFFFF.
- Undefined: no score port, no score logic.

Test Plan:
- Single hit: N=4, M=2; enemy1 at (100,50) alive; laser0 at (105,60) active; others off; pulse frame_start -> hits_valid on cycle 10; enemy_hit_vec=4'b0010, laser_hit_vec=2'b01; busy stays high until ack.
- Edge-inclusive/miss: enemy0 (100,100), laser0 x=130, y=100 -> hit. Same with laser0 x=131 -> no hit, vectors 0. Laser0 x=80 (lx+W=100) -> hit.
- Contention: enemies 0 and 2 both overlap laser0; laser1 also overlaps enemy0 -> enemy_hit_vec=4'b0001, laser_hit_vec=2'b01.
- Handshake/overrun: hold hits_ack=0 for 20 cycles -> vectors stable. Pulse frame_start during REPORT -> overrun=1, no rescan. Ack -> busy=0 next cycle.
- Reset mid-scan: assert Reset at SCAN cycle 3 -> next edge all outputs 0, state IDLE. New frame_start gives a correct fresh result.
- HIT_SCORE_EN: two frames, 2 then 1 enemy hit -> score 20 then 30. Preload 16'hFFFA plus one hit -> 16'hFFFF.

Source files
------------

// File: rtl/hit_scheduler.sv
// Per-frame collision scheduler: one shared rectangle-overlap comparator walks every
// (enemy, laser) pair, laser-major. Define HIT_SCORE_EN to add a saturating score output.
module hit_scheduler #(
  parameter int NUM_ENEMIES = 4,
  parameter int NUM_LASERS  = 2,
  parameter int ENEMY_SIZE  = 30,
  parameter int LASER_W     = 20,
  parameter int LASER_H     = 49
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_start,
  input  logic [NUM_ENEMIES-1:0]    enemy_alive,
  input  logic [10*NUM_ENEMIES-1:0] enemy_x_flat,
  input  logic [10*NUM_ENEMIES-1:0] enemy_y_flat,
  input  logic [NUM_LASERS-1:0]     laser_active,
  input  logic [10*NUM_LASERS-1:0]  laser_x_flat,
  input  logic [10*NUM_LASERS-1:0]  laser_y_flat,
  output logic                     busy,
  output logic                     hits_valid,
  input  logic                     hits_ack,
  output logic [NUM_ENEMIES-1:0]    enemy_hit_vec,
  output logic [NUM_LASERS-1:0]     laser_hit_vec,
`ifdef HIT_SCORE_EN
  output logic [15:0]              score,
`endif
  output logic                     overrun
);

  localparam int EW = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int LW = (NUM_LASERS > 1) ? $clog2(NUM_LASERS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_e;

  state_e                 state_q, state_d;
  logic [EW-1:0]          e_q, e_d;
  logic [LW-1:0]          l_q, l_d;
  logic [NUM_ENEMIES-1:0] enemy_hit_q, enemy_hit_d;
  logic [NUM_LASERS-1:0]  laser_hit_q, laser_hit_d;
  logic                   busy_q, busy_d;
  logic                   hits_valid_q, hits_valid_d;
  logic                   overrun_q, overrun_d;
  logic [10:0]            ex, ey, lx, ly;
  logic                   overlap, hit;

  // Operands widened to 11 bits so edge sums never wrap.
  always_comb begin
    ex = {1'b0, enemy_x_flat[int'(e_q)*10 +: 10]};
    ey = {1'b0, enemy_y_flat[int'(e_q)*10 +: 10]};
    lx = {1'b0, laser_x_flat[int'(l_q)*10 +: 10]};
    ly = {1'b0, laser_y_flat[int'(l_q)*10 +: 10]};
    overlap = (lx <= ex + 11'(ENEMY_SIZE)) && (lx + 11'(LASER_W) >= ex) &&
              (ly <= ey + 11'(ENEMY_SIZE)) && (ly + 11'(LASER_H) >= ey);
    hit = enemy_alive[e_q] && laser_active[l_q] && !laser_hit_q[l_q] &&
          !enemy_hit_q[e_q] && overlap;
  end

`ifdef HIT_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [4:0]  pop;
  logic [16:0] sum;
`endif

  always_comb begin
    state_d      = state_q;
    e_d          = e_q;
    l_d          = l_q;
    enemy_hit_d  = enemy_hit_q;
    laser_hit_d  = laser_hit_q;
    busy_d       = busy_q;
    hits_valid_d = hits_valid_q;
    overrun_d    = overrun_q | (frame_start & busy_q);
`ifdef HIT_SCORE_EN
    score_d = score_q;
    pop     = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) pop = pop + 5'(enemy_hit_q[i]);
    sum     = {1'b0, score_q} + 17'(pop) * 17'd10;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          enemy_hit_d = '0;
          laser_hit_d = '0;
          e_d         = '0;
          l_d         = '0;
          busy_d      = 1'b1;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          enemy_hit_d[e_q] = 1'b1;
          laser_hit_d[l_q] = 1'b1;
        end
        if (e_q == EW'(NUM_ENEMIES - 1)) begin
          e_d = '0;
          if (l_q == LW'(NUM_LASERS - 1)) begin
            hits_valid_d = 1'b1;
            state_d      = REPORT;
          end else begin
            l_d = l_q + 1'b1;
          end
        end else begin
          e_d = e_q + 1'b1;
        end
      end
      REPORT: begin
        if (hits_ack) begin
          hits_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
`ifdef HIT_SCORE_EN
          score_d = sum[16] ? 16'hFFFF : sum[15:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      e_q          <= '0;
      l_q          <= '0;
      enemy_hit_q  <= '0;
      laser_hit_q  <= '0;
      busy_q       <= 1'b0;
      hits_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef HIT_SCORE_EN
      score_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      e_q          <= e_d;
      l_q          <= l_d;
      enemy_hit_q  <= enemy_hit_d;
      laser_hit_q  <= laser_hit_d;
      busy_q       <= busy_d;
      hits_valid_q <= hits_valid_d;
      overrun_q    <= overrun_d;
`ifdef HIT_SCORE_EN
      score_q      <= score_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign hits_valid    = hits_valid_q;
  assign enemy_hit_vec = enemy_hit_q;
  assign laser_hit_vec = laser_hit_q;
  assign overrun       = overrun_q;
`ifdef HIT_SCORE_EN
  assign score = score_q;
`endif

endmodule

// File: tb/tb_hit_scheduler.sv
// Directed bench for hit_scheduler (4 enemies, 2 lasers): latency, edges, contention,
// handshake/overrun, mid-scan reset, and score when HIT_SCORE_EN is defined.
module tb_hit_scheduler;
  localparam int N = 4;
  localparam int M = 2;

  logic            Clk = 1'b0;
  logic            Reset, frame_start, hits_ack;
  logic [N-1:0]    enemy_alive;
  logic [10*N-1:0] enemy_x_flat, enemy_y_flat;
  logic [M-1:0]    laser_active;
  logic [10*M-1:0] laser_x_flat, laser_y_flat;
  logic            busy, hits_valid, overrun;
  logic [N-1:0]    enemy_hit_vec;
  logic [M-1:0]    laser_hit_vec;
`ifdef HIT_SCORE_EN
  logic [15:0]     score;
`endif

  int tests = 0;
  int fails = 0;
  int lat;

  hit_scheduler #(.NUM_ENEMIES(N), .NUM_LASERS(M)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .enemy_alive(enemy_alive), .enemy_x_flat(enemy_x_flat), .enemy_y_flat(enemy_y_flat),
    .laser_active(laser_active), .laser_x_flat(laser_x_flat), .laser_y_flat(laser_y_flat),
    .busy(busy), .hits_valid(hits_valid), .hits_ack(hits_ack),
    .enemy_hit_vec(enemy_hit_vec), .laser_hit_vec(laser_hit_vec),
`ifdef HIT_SCORE_EN
    .score(score),
`endif
    .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_objs();
    enemy_alive = '0; laser_active = '0;
    enemy_x_flat = '0; enemy_y_flat = '0;
    laser_x_flat = '0; laser_y_flat = '0;
  endtask

  task automatic set_enemy(input int i, input int x, input int y);
    enemy_alive[i] = 1'b1;
    enemy_x_flat[i*10 +: 10] = 10'(x);
    enemy_y_flat[i*10 +: 10] = 10'(y);
  endtask

  task automatic set_laser(input int j, input int x, input int y);
    laser_active[j] = 1'b1;
    laser_x_flat[j*10 +: 10] = 10'(x);
    laser_y_flat[j*10 +: 10] = 10'(y);
  endtask

  // Returns edges from the frame_start edge up to the one raising hits_valid.
  task automatic run_frame(output int edges);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    edges = 1;
    while (!hits_valid && edges < 50) begin
      tick();
      edges++;
    end
  endtask

  task automatic ack();
    hits_ack = 1'b1;
    tick();
    hits_ack = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; hits_ack = 1'b0;
    clear_objs();
    tick(); tick();
    Reset = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(hits_valid), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_evec", 32'(enemy_hit_vec), 0);
    chk("rst_lvec", 32'(laser_hit_vec), 0);

    // Single hit; valid visible on cycle N*M+2 after frame_start.
    set_enemy(1, 100, 50);
    set_laser(0, 105, 60);
    run_frame(lat);
    chk("single_lat", 32'(lat), 32'(N*M+1));
    chk("single_busy", 32'(busy), 1);
    chk("single_evec", 32'(enemy_hit_vec), 32'b0010);
    chk("single_lvec", 32'(laser_hit_vec), 32'b01);
    ack();
    chk("single_ack_busy", 32'(busy), 0);
    chk("single_ack_valid", 32'(hits_valid), 0);

    // Inclusive right edge.
    clear_objs();
    set_enemy(0, 100, 100);
    set_laser(0, 130, 100);
    run_frame(lat);
    chk("edge130_evec", 32'(enemy_hit_vec), 32'b0001);
    chk("edge130_lvec", 32'(laser_hit_vec), 32'b01);
    ack();
    laser_x_flat[9:0] = 10'd131;
    run_frame(lat);
    chk("miss131_evec", 32'(enemy_hit_vec), 0);
    chk("miss131_lvec", 32'(laser_hit_vec), 0);
    ack();
    laser_x_flat[9:0] = 10'd80;
    run_frame(lat);
    chk("edge80_evec", 32'(enemy_hit_vec), 32'b0001);
    chk("edge80_lvec", 32'(laser_hit_vec), 32'b01);
    ack();

    // Contention: laser0 overlaps e0,e2 (e0 wins); laser1 overlaps only e0, already taken.
    clear_objs();
    set_enemy(0, 100, 100);
    set_enemy(2, 120, 100);
    set_laser(0, 125, 100);
    set_laser(1, 85, 100);
    run_frame(lat);
    chk("cont_evec", 32'(enemy_hit_vec), 32'b0001);
    chk("cont_lvec", 32'(laser_hit_vec), 32'b01);
    ack();

    // Handshake hold, overrun during REPORT, no rescan.
    clear_objs();
    set_enemy(1, 100, 50);
    set_laser(0, 105, 60);
    run_frame(lat);
    repeat (20) tick();
    chk("hold_valid", 32'(hits_valid), 1);
    chk("hold_evec", 32'(enemy_hit_vec), 32'b0010);
    chk("hold_lvec", 32'(laser_hit_vec), 32'b01);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_valid", 32'(hits_valid), 1);
    chk("ovr_evec", 32'(enemy_hit_vec), 32'b0010);
    ack();
    chk("ovr_ack_busy", 32'(busy), 0);
    repeat (3) tick();
    chk("no_rescan_busy", 32'(busy), 0);
    chk("ovr_sticky", 32'(overrun), 1);

    // Reset at SCAN cycle 3, then a fresh frame.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_valid", 32'(hits_valid), 0);
    chk("mrst_evec", 32'(enemy_hit_vec), 0);
    chk("mrst_lvec", 32'(laser_hit_vec), 0);
    chk("mrst_ovr", 32'(overrun), 0);
    run_frame(lat);
    chk("fresh_lat", 32'(lat), 32'(N*M+1));
    chk("fresh_evec", 32'(enemy_hit_vec), 32'b0010);
    chk("fresh_lvec", 32'(laser_hit_vec), 32'b01);
    ack();

`ifdef HIT_SCORE_EN
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("score_rst", 32'(score), 0);
    clear_objs();
    set_enemy(0, 100, 100);
    set_enemy(1, 300, 100);
    set_laser(0, 105, 100);
    set_laser(1, 305, 100);
    run_frame(lat);
    ack();
    chk("score_20", 32'(score), 32'd20);
    clear_objs();
    set_enemy(1, 100, 50);
    set_laser(0, 105, 60);
    run_frame(lat);
    ack();
    chk("score_30", 32'(score), 32'd30);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
